key_event_ctrl: RTL and testbench

Sequences the raw byte stream from the PS/2 receiver into debounced key press/release events for the game controller. Tracks the set-2 E0 (extended) and F0 (break) prefixes, filters typematic repeats against a held-key bitmap, and queues events in a small FIFO popped by the game control FSM with a valid/ready handshake. It sits between the PS/2 receiver (scancode, valid) and the top-level game logic (run/pause, cursor movement, cell toggle).

---
 rtl/key_event_ctrl_if.sv | 28 ++
 rtl/key_event_ctrl.sv | 156 +++++++++++++++
 tb/tb_key_event_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_event_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : key_event_ctrl_if
// Brief    : Key event stream (valid/ready) between key_event_ctrl and the
//            game control FSM.
// Revision : 1.0
// ============================================================================
interface key_event_ctrl_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_key;
    logic       evt_press;

    modport master (
        output evt_valid,
        output evt_key,
        output evt_press,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_key,
        input  evt_press,
        output evt_ready
    );
endinterface
`default_nettype wire

// File: rtl/key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_event_ctrl
// Brief    : PS/2 set-2 scancode sequencer: prefix tracking, typematic filter,
//            held-key bitmap and event FIFO.
// Revision : 1.0
// ============================================================================
module key_event_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    scancode,
    input  logic                          valid,
    input  logic                          clear_overflow,
    key_event_ctrl_if.master              evt,
    output logic [15:0]                   key_state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;
    localparam int c_TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [c_TMR_W-1:0]    r_timer;
    logic [4:0]            r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0]   r_wr_ptr, r_rd_ptr;

    logic                  w_is_ext, w_is_brk, w_hit, w_held;
    logic [3:0]            w_id;
    logic [4:0]            w_lookup;
    logic                  w_make_evt, w_break_evt, w_push, w_pop, w_full, w_wr_en;

    // Returns {hit, key_id}; extended and plain code spaces never alias.
    function automatic logic [4:0] lookup(input logic ext, input logic [7:0] code);
        logic [4:0] res;
        res = 5'd0;
        if (ext) begin
            case (code)
                8'h75:   res = {1'b1, 4'd0};
                8'h72:   res = {1'b1, 4'd1};
                8'h6B:   res = {1'b1, 4'd2};
                8'h74:   res = {1'b1, 4'd3};
                default: res = 5'd0;
            endcase
        end else begin
            case (code)
                8'h29:   res = {1'b1, 4'd4};
                8'h5A:   res = {1'b1, 4'd5};
                8'h76:   res = {1'b1, 4'd6};
                8'h1D:   res = {1'b1, 4'd7};
                8'h1C:   res = {1'b1, 4'd8};
                8'h1B:   res = {1'b1, 4'd9};
                8'h23:   res = {1'b1, 4'd10};
                8'h4D:   res = {1'b1, 4'd11};
                8'h2D:   res = {1'b1, 4'd12};
                8'h21:   res = {1'b1, 4'd13};
                8'h79:   res = {1'b1, 4'd14};
                8'h7B:   res = {1'b1, 4'd15};
                default: res = 5'd0;
            endcase
        end
        return res;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_make_evt  = 1'b0;
        w_break_evt = 1'b0;
        w_is_ext    = (r_state == S_EXT) || (r_state == S_EXT_BRK);
        w_is_brk    = (r_state == S_BRK) || (r_state == S_EXT_BRK);
        w_lookup    = lookup(w_is_ext, scancode);
        w_hit       = w_lookup[4];
        w_id        = w_lookup[3:0];
        w_held      = key_state[w_id];
        if (valid) begin
            case (scancode)
                8'hE0:   w_state_nxt = S_EXT;
                8'hF0:   w_state_nxt = w_is_ext ? S_EXT_BRK : S_BRK;
                default: begin
                    w_state_nxt = S_IDLE;
                    if (w_hit) begin
                        w_break_evt = w_is_brk & w_held;
                        w_make_evt  = ~w_is_brk & ~w_held;
                    end
                end
            endcase
        end else if (r_state != S_IDLE && r_timer == c_TMR_LAST) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Saturates so an idle link never wraps back into a spurious timeout.
    always_ff @(posedge clock) begin
        if (reset)                    r_timer <= '0;
        else if (valid)               r_timer <= '0;
        else if (r_timer != c_TMR_LAST) r_timer <= r_timer + c_TMR_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset)            key_state       <= 16'd0;
        else if (w_make_evt)  key_state[w_id] <= 1'b1;
        else if (w_break_evt) key_state[w_id] <= 1'b0;
    end

    assign w_push  = w_make_evt | w_break_evt;
    assign w_pop   = evt.evt_valid & evt.evt_ready;
    assign w_full  = (fifo_count == c_FULL);
    assign w_wr_en = w_push & (~w_full | w_pop);

    always_ff @(posedge clock) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= {w_make_evt, w_id};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            case ({w_wr_en, w_pop})
                2'b10:   fifo_count <= fifo_count + c_CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - c_CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (w_push && w_full && !w_pop) overflow <= 1'b1;
            else if (clear_overflow)        overflow <= 1'b0;
        end
    end

    assign evt.evt_valid = (fifo_count != '0);
    assign evt.evt_key   = evt.evt_valid ? r_mem[r_rd_ptr][3:0] : 4'd0;
    assign evt.evt_press = evt.evt_valid ? r_mem[r_rd_ptr][4]   : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_event_ctrl
// Brief    : Scoreboard bench for key_event_ctrl (short timeout, depth 8).
// Revision : 1.0
// ============================================================================
module tb_key_event_ctrl;

    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  scancode = 8'd0;
    logic        valid = 1'b0;
    logic        clear_overflow = 1'b0;
    logic [15:0] key_state;
    logic [3:0]  fifo_count;
    logic        overflow;

    key_event_ctrl_if evt_if();

    key_event_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock          (clock),
        .reset          (reset),
        .scancode       (scancode),
        .valid          (valid),
        .clear_overflow (clear_overflow),
        .evt            (evt_if),
        .key_state      (key_state),
        .fifo_count     (fifo_count),
        .overflow       (overflow)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [4:0] exp_q[$];   // {press, key}

    // All tasks enter and leave on a falling edge.
    task automatic send(input logic [7:0] b);
        valid    = 1'b1;
        scancode = b;
        @(negedge clock);
        valid    = 1'b0;
        scancode = 8'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_evt(input logic p, input logic [3:0] k);
        exp_q.push_back({p, k});
    endtask

    task automatic drain();
        logic [4:0] e;
        while (exp_q.size() != 0) begin
            n_checks++;
            if (evt_if.evt_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL drain_valid: evt_valid=%b, required 1 with %0d events pending",
                         evt_if.evt_valid, exp_q.size());
                exp_q.delete();
                break;
            end
            e = exp_q.pop_front();
            n_checks++;
            if ({evt_if.evt_press, evt_if.evt_key} !== e) begin
                n_errors++;
                $display("FAIL drain_head: press=%b key=%0d, required press=%b key=%0d",
                         evt_if.evt_press, evt_if.evt_key, e[4], e[3:0]);
            end
            evt_if.evt_ready = 1'b1;
            @(negedge clock);
            evt_if.evt_ready = 1'b0;
        end
        n_checks++;
        if (evt_if.evt_valid !== 1'b0 || fifo_count !== 4'd0 ||
            evt_if.evt_key !== 4'd0 || evt_if.evt_press !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_empty: valid=%b count=%0d key=%0d press=%b, required 0 0 0 0",
                     evt_if.evt_valid, fifo_count, evt_if.evt_key, evt_if.evt_press);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        n_checks++;
        if ({evt_if.evt_valid, evt_if.evt_key, evt_if.evt_press, key_state, fifo_count, overflow} !== 27'd0) begin
            n_errors++;
            $display("FAIL reset_vals: valid=%b key=%0d press=%b ks=%h count=%0d ovf=%b, required all 0",
                     evt_if.evt_valid, evt_if.evt_key, evt_if.evt_press, key_state, fifo_count, overflow);
        end
    endtask

    task automatic test_press_release();
        send(8'h29); expect_evt(1'b1, 4'd4);
        n_checks++;
        if (key_state[4] !== 1'b1 || fifo_count !== 4'd1 || evt_if.evt_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL press_latency: ks4=%b count=%0d valid=%b, required 1 1 1",
                     key_state[4], fifo_count, evt_if.evt_valid);
        end
        send(8'hF0); send(8'h29); expect_evt(1'b0, 4'd4);
        n_checks++;
        if (key_state[4] !== 1'b0 || fifo_count !== 4'd2) begin
            n_errors++;
            $display("FAIL release: ks4=%b count=%0d, required 0 2", key_state[4], fifo_count);
        end
        drain();
    endtask

    task automatic test_typematic();
        for (int i = 0; i < 3; i++) begin
            send(8'hE0); send(8'h75);
        end
        expect_evt(1'b1, 4'd0);
        n_checks++;
        if (fifo_count !== 4'd1 || key_state !== 16'h0001) begin
            n_errors++;
            $display("FAIL typematic: count=%0d ks=%h, required 1 0001", fifo_count, key_state);
        end
        send(8'hE0); send(8'hF0); send(8'h75); expect_evt(1'b0, 4'd0);
        send(8'h75);
        n_checks++;
        if (fifo_count !== 4'd2 || key_state !== 16'h0000) begin
            n_errors++;
            $display("FAIL plain_75: count=%0d ks=%h, required 2 0000", fifo_count, key_state);
        end
        drain();
    endtask

    task automatic test_timeout();
        send(8'hE0); idle(TMO); send(8'h74);
        n_checks++;
        if (fifo_count !== 4'd0 || key_state !== 16'h0000) begin
            n_errors++;
            $display("FAIL timeout_fire: count=%0d ks=%h, required 0 0000", fifo_count, key_state);
        end
        send(8'hE0); idle(TMO - 1); send(8'h74); expect_evt(1'b1, 4'd3);
        n_checks++;
        if (fifo_count !== 4'd1 || key_state !== 16'h0008) begin
            n_errors++;
            $display("FAIL timeout_edge: count=%0d ks=%h, required 1 0008", fifo_count, key_state);
        end
        send(8'hE0); send(8'hF0); send(8'h74); expect_evt(1'b0, 4'd3);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes [6];
        codes = '{8'hE0, 8'hF0, 8'hE0, 8'h6B, 8'hAA, 8'hFA};
        // Pop request on an empty FIFO must not swallow the incoming push.
        evt_if.evt_ready = 1'b1;
        send(8'h5A);
        evt_if.evt_ready = 1'b0;
        expect_evt(1'b1, 4'd5);
        n_checks++;
        if (fifo_count !== 4'd1) begin
            n_errors++;
            $display("FAIL empty_push_pop: count=%0d, required 1", fifo_count);
        end
        foreach (codes[i]) send(codes[i]);
        expect_evt(1'b1, 4'd2);
        send(8'h6B);
        send(8'hF0); send(8'h5A); expect_evt(1'b0, 4'd5);
        send(8'hE0); send(8'hF0); send(8'h6B); expect_evt(1'b0, 4'd2);
        n_checks++;
        if (fifo_count !== 4'd4 || key_state !== 16'h0000 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_stream: count=%0d ks=%h ovf=%b, required 4 0000 0",
                     fifo_count, key_state, overflow);
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        int         ev;
        codes = '{8'h29, 8'h5A, 8'h76, 8'h1D, 8'h1C};
        ev = 0;
        for (int i = 0; i < 5; i++) begin
            send(codes[i]);
            if (ev < DEPTH) expect_evt(1'b1, 4'(i + 4));
            ev++;
            send(8'hF0); send(codes[i]);
            if (ev < DEPTH) expect_evt(1'b0, 4'(i + 4));
            ev++;
        end
        n_checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1 || key_state !== 16'h0000) begin
            n_errors++;
            $display("FAIL overflow_fill: count=%0d ovf=%b ks=%h, required 8 1 0000",
                     fifo_count, overflow, key_state);
        end
        drain();
        n_checks++;
        if (overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_sticky: ovf=%b, required 1", overflow);
        end
        clear_overflow = 1'b1;
        @(negedge clock);
        clear_overflow = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL overflow_clear: ovf=%b, required 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] codes [4];
        logic [4:0] e;
        codes = '{8'h1D, 8'h1C, 8'h1B, 8'h23};
        for (int i = 0; i < 4; i++) begin
            send(codes[i]);              expect_evt(1'b1, 4'(i + 7));
            send(8'hF0); send(codes[i]); expect_evt(1'b0, 4'(i + 7));
        end
        n_checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL full_fill: count=%0d ovf=%b, required 8 0", fifo_count, overflow);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({evt_if.evt_press, evt_if.evt_key} !== e) begin
            n_errors++;
            $display("FAIL full_head: press=%b key=%0d, required press=%b key=%0d",
                     evt_if.evt_press, evt_if.evt_key, e[4], e[3:0]);
        end
        evt_if.evt_ready = 1'b1;
        send(8'h2D);
        evt_if.evt_ready = 1'b0;
        expect_evt(1'b1, 4'd12);
        n_checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b0 || key_state !== 16'h1000) begin
            n_errors++;
            $display("FAIL full_push_pop: count=%0d ovf=%b ks=%h, required 8 0 1000",
                     fifo_count, overflow, key_state);
        end
        drain();
        send(8'hF0); send(8'h2D); expect_evt(1'b0, 4'd12);
        drain();
    endtask

    task automatic test_reset_mid();
        send(8'h29);
        send(8'hE0); send(8'hF0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if (fifo_count !== 4'd0 || key_state !== 16'h0000 || evt_if.evt_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: count=%0d ks=%h valid=%b, required 0 0000 0",
                     fifo_count, key_state, evt_if.evt_valid);
        end
        send(8'h6B);
        n_checks++;
        if (fifo_count !== 4'd0 || key_state !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_prefix: count=%0d ks=%h, required 0 0000", fifo_count, key_state);
        end
        send(8'h29);               expect_evt(1'b1, 4'd4);
        send(8'hF0); send(8'h29);  expect_evt(1'b0, 4'd4);
        drain();
    endtask

    initial begin
        evt_if.evt_ready = 1'b0;
        @(negedge clock);
        test_reset();
        test_press_release();
        test_typematic();
        test_timeout();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
